// File: rtl/regfile_mp_scoreboard_pkg.sv
// rtl/regfile_mp_scoreboard_pkg.sv - shared constants and types for the register file
// Purpose: architectural register file dimensions and index/data types
//   used by the multi-ported register file and its scoreboard.
// Ports: none (package).
package regfile_mp_scoreboard_pkg;

  localparam int REG_NUM      = 32;
  localparam int REG_WIDTH    = 32;
  localparam int RF_NUM_READ  = 2;
  localparam int RF_NUM_WRITE = 2;
  localparam int RF_ADDR_W    = $clog2(REG_NUM);

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_mp_scoreboard_rf_scoreboard.sv
// rtl/regfile_mp_scoreboard_rf_scoreboard.sv - busy-bit scoreboard for the register file
// Purpose: holds one busy bit per register. Decode claims a destination,
//   writeback releases it. Produces claim acceptance and per-operand busy.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_write_enable    per write port strobe (releases the target)
//   i_write_select    per write port destination index
//   i_read_select     per read port operand index
//   o_read_busy       per read port pending flag (combinational)
//   i_claim_enable    claim request
//   i_claim_select    register to claim
//   o_claim_ready     claim accepted this cycle (combinational)
//   o_busy_vec        registered busy bits
module rf_scoreboard
  import regfile_mp_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = REG_NUM,
  parameter int NUM_READ  = RF_NUM_READ,
  parameter int NUM_WRITE = RF_NUM_WRITE,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WRITE-1:0]             i_write_enable,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0] i_write_select,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]  i_read_select,
  output logic [NUM_READ-1:0]              o_read_busy,
  input  logic                             i_claim_enable,
  input  logic [ADDR_W-1:0]                i_claim_select,
  output logic                             o_claim_ready,
  output logic [NUM_REGS-1:0]              o_busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                claim_write_hit;
  logic                claim_is_zero;

  assign claim_is_zero = (ZERO_REG != 0) && (i_claim_select == '0);

  // A write landing on the claimed register this cycle frees it, so the
  // claim can be accepted back-to-back with the release.
  always_comb begin
    claim_write_hit = 1'b0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (i_write_enable[p] && (i_write_select[p] == i_claim_select)) begin
        claim_write_hit = 1'b1;
      end
    end
  end

  always_comb begin
    o_claim_ready = 1'b0;
    if (i_claim_enable) begin
      o_claim_ready = claim_is_zero || !busy_q[i_claim_select] || claim_write_hit;
    end
  end

  // Operand busy is hidden only when the pending value is forwarded now.
  always_comb begin
    o_read_busy = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      o_read_busy[r] = busy_q[i_read_select[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (i_write_enable[p] && (i_write_select[p] == i_read_select[r])) begin
            o_read_busy[r] = 1'b0;
          end
        end
      end
    end
  end

  // Releases first, then the claim, so a claim beats a release on the same index.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (i_write_enable[p]) begin
        busy_d[i_write_select[p]] = 1'b0;
      end
    end
    if (o_claim_ready && !claim_is_zero) begin
      busy_d[i_claim_select] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign o_busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-ported register file with busy-bit scoreboard
// Purpose: NUM_READ combinational read ports and NUM_WRITE write ports
//   (higher port index is the younger result), optional hardwired-zero r0,
//   optional same-cycle write-to-read bypass, and a scoreboard for claims.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_write_enable    per write port strobe
//   i_write_select    per write port destination index
//   i_write_data      per write port data
//   i_read_select     per read port operand index
//   o_read_data       per read port operand data (combinational)
//   o_read_busy       per read port pending flag (combinational)
//   i_claim_enable    request to mark a destination busy
//   i_claim_select    register to claim
//   o_claim_ready     claim accepted this cycle (combinational)
//   o_busy_vec        registered busy bits
module regfile_mp_scoreboard
  import regfile_mp_scoreboard_pkg::*;
#(
  parameter int   NUM_REGS  = REG_NUM,
  parameter int   DATA_W    = REG_WIDTH,
  parameter int   NUM_READ  = RF_NUM_READ,
  parameter int   NUM_WRITE = RF_NUM_WRITE,
  parameter int   ZERO_REG  = 1,
  parameter int   BYPASS    = 1,
  localparam int  ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WRITE-1:0]             i_write_enable,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0] i_write_select,
  input  logic [NUM_WRITE-1:0][DATA_W-1:0] i_write_data,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]  i_read_select,
  output logic [NUM_READ-1:0][DATA_W-1:0]  o_read_data,
  output logic [NUM_READ-1:0]              o_read_busy,
  input  logic                             i_claim_enable,
  input  logic [ADDR_W-1:0]                i_claim_select,
  output logic                             o_claim_ready,
  output logic [NUM_REGS-1:0]              o_busy_vec
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Ports are applied in ascending order so the highest port wins a conflict.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (i_write_enable[p] && !((ZERO_REG != 0) && (i_write_select[p] == '0))) begin
        regs_d[i_write_select[p]] = i_write_data[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    o_read_data = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      o_read_data[r] = regs_q[i_read_select[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (i_write_enable[p] && (i_write_select[p] == i_read_select[r])) begin
            o_read_data[r] = i_write_data[p];
          end
        end
      end
      // Forwarding must not leak a dropped r0 write.
      if ((ZERO_REG != 0) && (i_read_select[r] == '0)) begin
        o_read_data[r] = '0;
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_READ  (NUM_READ),
    .NUM_WRITE (NUM_WRITE),
    .ADDR_W    (ADDR_W),
    .ZERO_REG  (ZERO_REG),
    .BYPASS    (BYPASS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .i_write_enable (i_write_enable),
    .i_write_select (i_write_select),
    .i_read_select  (i_read_select),
    .o_read_busy    (o_read_busy),
    .i_claim_enable (i_claim_enable),
    .i_claim_select (i_claim_select),
    .o_claim_ready  (o_claim_ready),
    .o_busy_vec     (o_busy_vec)
  );

endmodule
